// File: rtl/mips_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mips_trace_buffer
// Description : Retired-instruction trace buffer for the MIPS debug path.
//               Captures {pc, instr} per retire strobe into a circular
//               buffer, stops POST_TRIG entries after a masked instruction
//               match, and reads frozen contents back oldest-first.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_trace_buffer #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 32,
    parameter int POST_TRIG = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_instr,
    input  logic              i_arm,
    input  logic [DATA_W-1:0] i_trig_mask,
    input  logic [DATA_W-1:0] i_trig_value,
    input  logic [ADDR_W-1:0] i_rd_idx,
    output logic [DATA_W-1:0] o_rd_pc,
    output logic [DATA_W-1:0] o_rd_instr,
    output logic [ADDR_W:0]   o_count,
    output logic [ADDR_W-1:0] o_trig_pos,
    output logic [1:0]        o_state,
    output logic              o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   c_DEPTH_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_POST      = ADDR_W'(POST_TRIG);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_clear;
    logic                w_capture;
    logic                w_hit;
    logic                w_trig_take;

    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W-1:0]   r_trig_slot;
    logic [ADDR_W-1:0]   r_post_cnt;
    logic [DATA_W-1:0]   r_rd_pc;
    logic [DATA_W-1:0]   r_rd_instr;

    logic [DATA_W-1:0]   r_mem_pc    [DEPTH];
    logic [DATA_W-1:0]   r_mem_instr [DEPTH];

    logic [ADDR_W-1:0]   w_oldest;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_rd_empty;

    assign w_hit = i_valid &&
                   ((i_instr & i_trig_mask) == (i_trig_value & i_trig_mask));

    // State register; reset aborts any capture in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and capture control; arm always wins over a same-cycle strobe.
    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_capture    = 1'b0;
        w_trig_take  = 1'b0;
        if (i_arm) begin
            w_next_state = S_ARMED;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (i_valid) begin
                        w_capture = 1'b1;
                        if (w_hit) begin
                            w_trig_take  = 1'b1;
                            w_next_state = (POST_TRIG == 0) ? S_DONE : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (i_valid) begin
                        w_capture = 1'b1;
                        if (r_post_cnt == ADDR_W'(1)) begin
                            w_next_state = S_DONE;
                        end
                    end
                end
                default: begin
                    w_next_state = r_state;
                end
            endcase
        end
    end

    // Write pointer, fill count, trigger slot and post-trigger countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_trig_slot <= '0;
            r_post_cnt  <= '0;
        end else if (w_clear) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_trig_slot <= '0;
            r_post_cnt  <= '0;
        end else if (w_capture) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (r_count != c_DEPTH_CNT) begin
                r_count <= r_count + (ADDR_W+1)'(1);
            end
            if (w_trig_take) begin
                r_trig_slot <= r_wr_ptr;
                r_post_cnt  <= c_POST;
            end else if (r_state == S_POST) begin
                r_post_cnt <= r_post_cnt - ADDR_W'(1);
            end
        end
    end

    // Trace storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mem_pc[r_wr_ptr]    <= i_pc;
            r_mem_instr[r_wr_ptr] <= i_instr;
        end
    end

    // Oldest entry sits at the write pointer once the buffer has wrapped.
    always_comb begin
        w_oldest   = (r_count == c_DEPTH_CNT) ? r_wr_ptr : '0;
        w_rd_addr  = w_oldest + i_rd_idx;
        w_rd_empty = ({1'b0, i_rd_idx} >= r_count);
    end

    // Registered readout; unfilled indices read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
        end else if (w_rd_empty) begin
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
        end else begin
            r_rd_pc    <= r_mem_pc[w_rd_addr];
            r_rd_instr <= r_mem_instr[w_rd_addr];
        end
    end

    assign o_rd_pc    = r_rd_pc;
    assign o_rd_instr = r_rd_instr;
    assign o_count    = r_count;
    assign o_trig_pos = r_trig_slot - w_oldest;
    assign o_state    = r_state;
    assign o_done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mips_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_trace_buffer
// Description : Directed self-checking bench for mips_trace_buffer with a
//               readout scoreboard (expected entries queued on each read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_trace_buffer;

    localparam int DEPTH     = 8;
    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 32;
    localparam int POST_TRIG = 2;

    logic              clk;
    logic              rst_n;
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              arm;
    logic [DATA_W-1:0] trig_mask;
    logic [DATA_W-1:0] trig_value;
    logic [ADDR_W-1:0] rd_idx;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_instr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] trig_pos;
    logic [1:0]        state;
    logic              done;

    int errors = 0;
    int checks = 0;

    logic [2*DATA_W-1:0] sb_q[$];

    mips_trace_buffer #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .POST_TRIG (POST_TRIG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (valid),
        .i_pc         (pc),
        .i_instr      (instr),
        .i_arm        (arm),
        .i_trig_mask  (trig_mask),
        .i_trig_value (trig_value),
        .i_rd_idx     (rd_idx),
        .o_rd_pc      (rd_pc),
        .o_rd_instr   (rd_instr),
        .o_count      (count),
        .o_trig_pos   (trig_pos),
        .o_state      (state),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] ins);
        valid = 1'b1;
        pc    = p;
        instr = ins;
        step();
        valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    // Queue the expected entry, clock the read, then pop and compare.
    task automatic rd(input int idx, input logic [DATA_W-1:0] epc, input logic [DATA_W-1:0] eins);
        logic [2*DATA_W-1:0] e;
        rd_idx = ADDR_W'(idx);
        sb_q.push_back({epc, eins});
        step();
        e = sb_q.pop_front();
        chk($sformatf("rd_pc[%0d]", idx), 64'(rd_pc), 64'(e[2*DATA_W-1:DATA_W]));
        chk($sformatf("rd_instr[%0d]", idx), 64'(rd_instr), 64'(e[DATA_W-1:0]));
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; pc = '0; instr = '0; arm = 1'b0;
        trig_mask = '0; trig_value = '0; rd_idx = '0;
        step(); step();
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_rd_pc", 64'(rd_pc), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // 1: valids ignored in IDLE
        for (int k = 0; k < 10; k++) send(32'(4*k), 32'h1111_0000 + 32'(k));
        chk("t1_state", 64'(state), 64'd0);
        chk("t1_count", 64'(count), 64'd0);
        rd(0, 32'd0, 32'd0);
        chk("t1_done", 64'(done), 64'd0);

        // 2a: five entries, trigger never matches
        trig_mask = 32'hFFFF_FFFF; trig_value = 32'hDEAD_BEEF;
        do_arm();
        chk("t2_armed", 64'(state), 64'd1);
        chk("t2_count0", 64'(count), 64'd0);
        for (int k = 0; k < 5; k++) send(32'(4*k), 32'h2000_0000 + 32'(k));
        chk("t2_count", 64'(count), 64'd5);
        rd(0, 32'd0, 32'h2000_0000);
        rd(4, 32'd16, 32'h2000_0004);
        rd(5, 32'd0, 32'd0);

        // 2b: mask 0 -> first valid is the trigger, two more then frozen
        trig_mask = 32'h0; trig_value = 32'h1234_5678;
        do_arm();
        for (int k = 0; k < 5; k++) send(32'h100 + 32'(4*k), 32'h3000_0000 + 32'(k));
        chk("t2b_state", 64'(state), 64'd3);
        chk("t2b_count", 64'(count), 64'd3);
        chk("t2b_trig_pos", 64'(trig_pos), 64'd0);
        rd(2, 32'h108, 32'h3000_0002);
        rd(3, 32'd0, 32'd0);

        // 3: wrap, trigger at k=12, frozen after k=14
        trig_mask = 32'hFFFF_FFFF; trig_value = 32'h0800_0015;
        do_arm();
        for (int k = 0; k < 20; k++) begin
            send(32'(4*k), (k == 12) ? 32'h0800_0015 : 32'h0);
            if (k == 13) chk("t3_post", 64'(state), 64'd2);
            if (k == 14) chk("t3_done_state", 64'(state), 64'd3);
        end
        chk("t3_count", 64'(count), 64'd8);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_trig_pos", 64'(trig_pos), 64'd5);
        rd(0, 32'd28, 32'h0);
        rd(7, 32'd56, 32'h0);
        rd(5, 32'd48, 32'h0800_0015);

        // 4: opcode-field match on jal
        trig_mask = 32'hFC00_0000; trig_value = 32'h0C00_0000;
        do_arm();
        for (int k = 0; k < 7; k++) begin
            send(32'h0040_0000 + 32'(4*k), (k == 2) ? 32'h0C00_0010 : 32'h2008_0001);
            if (k == 3) chk("t4_post", 64'(state), 64'd2);
            if (k == 4) chk("t4_done", 64'(state), 64'd3);
        end
        chk("t4_count", 64'(count), 64'd5);
        chk("t4_trig_pos", 64'(trig_pos), 64'd2);
        rd(2, 32'h0040_0008, 32'h0C00_0010);

        // 5: arm during POST with a same-cycle valid
        trig_mask = 32'hFFFF_FFFF; trig_value = 32'hAAAA_0000;
        do_arm();
        send(32'h500, 32'hAAAA_0000);
        chk("t5_post", 64'(state), 64'd2);
        arm = 1'b1;
        send(32'h504, 32'h5555_0000);
        arm = 1'b0;
        chk("t5_rearmed", 64'(state), 64'd1);
        chk("t5_count0", 64'(count), 64'd0);
        send(32'h508, 32'h5555_0001);
        chk("t5_count1", 64'(count), 64'd1);
        rd(0, 32'h508, 32'h5555_0001);

        // 6: asynchronous reset mid-POST
        trig_value = 32'h1234_5678;
        do_arm();
        send(32'h600, 32'h0);
        send(32'h604, 32'h0);
        send(32'h608, 32'h1234_5678);
        chk("t6_post", 64'(state), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", 64'(state), 64'd0);
        chk("t6_rst_count", 64'(count), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) send(32'h700 + 32'(4*k), 32'h0);
        chk("t6_idle_state", 64'(state), 64'd0);
        chk("t6_idle_count", 64'(count), 64'd0);
        do_arm();
        send(32'h800, 32'h0);
        chk("t6_arm_count", 64'(count), 64'd1);
        rd(0, 32'h800, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
